// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared ALU: two requesters in, one response channel out.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational 32-bit ALU; result is
// registered and held on a single response channel until accepted.
module alu_share_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_share_arbiter_if.slave bus,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic        last_id;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_id_q;

    logic        any_v;
    logic        gnt;
    logic        accept;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_sel;

    // Shift amounts use the whole B operand; anything >= 32 saturates.
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
        logic big;
        big = |b[31:5];
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = big ? 32'h0 : (a >> b[4:0]);
            3'b101:  alu = big ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
            default: alu = 32'h0;
        endcase
    endfunction

    always_comb begin
        any_v = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            gnt = (FIXED_PRIO != 0) ? 1'b0 : ~last_id;
        else
            gnt = bus.req1_valid;
    end

    assign accept = reset && (state == IDLE) && any_v;
    assign op_a   = gnt ? bus.req1_a  : bus.req0_a;
    assign op_b   = gnt ? bus.req1_b  : bus.req0_b;
    assign op_sel = gnt ? bus.req1_op : bus.req0_op;

    assign bus.req0_ready = accept && !gnt;
    assign bus.req1_ready = accept && gnt;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_id_q    <= 1'b0;
            done_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (any_v) begin
                    rsp_data_q  <= alu(op_a, op_b, op_sel);
                    rsp_id_q    <= gnt;
                    last_id     <= gnt;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    done_cnt    <= done_cnt + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
